// File: rtl/mem_access_if.sv
// mem_access_if: EX-side pipeline and byte-wide RAM signals of the memory-access stage
interface mem_access_if;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic [3:0]  memOp_in;
    logic [31:0] memAddr_in;
    logic [31:0] memData_in;
    logic [7:0]  ramData_in;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;
    logic        stallReq_out;
    logic [31:0] ramAddr_out;
    logic [7:0]  ramData_out;
    logic        ramWE_out;
    modport master (
        output rdE_in, rdIdx_in, rdData_in, memOp_in, memAddr_in, memData_in, ramData_in,
        input  rdE_out, rdIdx_out, rdData_out, stallReq_out, ramAddr_out, ramData_out, ramWE_out
    );
    modport slave (
        input  rdE_in, rdIdx_in, rdData_in, memOp_in, memAddr_in, memData_in, ramData_in,
        output rdE_out, rdIdx_out, rdData_out, stallReq_out, ramAddr_out, ramData_out, ramWE_out
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: byte-serial load/store stage over an 8-bit RAM with EX->MEM/WB pass-through
module mem_access (
    input logic         clk_in,
    input logic         rst_in,
    mem_access_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2, DONE = 2'd3;
    localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7;
    logic [1:0]  state, cnt;
    logic [2:0]  n, cnt_e;
    logic [31:0] ld_buf, ext, addr_cnt;
    logic [7:0]  st_byte;
    logic        is_load, is_store, is_mem, stall;
    wire  [3:0]  op = bus.memOp_in;
    wire  [31:0] d = bus.memData_in;
    assign is_load  = op >= 4'd1 && op <= 4'd5;
    assign is_store = op >= 4'd6 && op <= 4'd8;
    assign is_mem   = is_load || is_store;
    assign n = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 3'd1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 3'd2 : 3'd4;
    // a 2-bit counter reads 0 after the fourth LOAD byte; treat that as 4
    assign cnt_e    = {cnt == 2'd0, cnt};
    assign addr_cnt = bus.memAddr_in + {30'd0, cnt};
    assign st_byte  = cnt == 2'd1 ? d[15:8] : cnt == 2'd2 ? d[23:16] : cnt == 2'd3 ? d[31:24] : d[7:0];
    assign ext = op == OP_LB  ? {{24{ld_buf[7]}}, ld_buf[7:0]} :
                 op == OP_LH  ? {{16{ld_buf[15]}}, ld_buf[15:0]} :
                 op == OP_LBU ? {24'd0, ld_buf[7:0]} :
                 op == OP_LHU ? {16'd0, ld_buf[15:0]} : ld_buf;
    assign stall = !rst_in && (state == LOAD || state == STORE || (state == IDLE && is_mem));
    assign bus.stallReq_out = stall;
    assign bus.ramWE_out    = !rst_in && ((state == IDLE && is_store) || state == STORE);
    assign bus.ramAddr_out  = rst_in ? 32'd0 :
                              (state == IDLE && is_mem) ? bus.memAddr_in :
                              (state == STORE || (state == LOAD && cnt_e < n)) ? addr_cnt : 32'd0;
    assign bus.ramData_out  = rst_in ? 8'd0 :
                              (state == IDLE && is_store) ? d[7:0] :
                              state == STORE ? st_byte : 8'd0;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            ld_buf         <= 32'd0;
            bus.rdE_out    <= 1'b0;
            bus.rdIdx_out  <= 5'd0;
            bus.rdData_out <= 32'd0;
        end else begin
            if (stall) begin
                bus.rdE_out    <= 1'b0;
                bus.rdIdx_out  <= 5'd0;
                bus.rdData_out <= 32'd0;
            end else if (state == DONE) begin
                bus.rdE_out    <= is_load && bus.rdE_in;
                bus.rdIdx_out  <= bus.rdIdx_in;
                bus.rdData_out <= is_load ? ext : 32'd0;
            end else begin
                bus.rdE_out    <= bus.rdE_in;
                bus.rdIdx_out  <= bus.rdIdx_in;
                bus.rdData_out <= bus.rdData_in;
            end
            if (state == IDLE && is_mem) begin
                cnt   <= 2'd1;
                state <= is_load ? LOAD : n == 3'd1 ? DONE : STORE;
            end else if (state == LOAD) begin
                ld_buf[{cnt - 2'd1, 3'b000} +: 8] <= bus.ramData_in;
                cnt <= cnt + 2'd1;
                if (cnt_e == n) state <= DONE;
            end else if (state == STORE) begin
                cnt <= cnt + 2'd1;
                if (cnt_e == n - 3'd1) state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, listed as name, direction, width, meaning:
- clk_in, in, 1, clock; all state updates occur on its rising edge.
- rst_in, in, 1, synchronous active-high reset.
- rdE_in, in, 1, register-write enable from EX.
- rdIdx_in, in, 5, destination register index from EX.
- rdData_in, in, 32, EX result.
- memOp_in, in, 4, memory operation: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE.
- memAddr_in, in, 32, byte address of the access.
- memData_in, in, 32, store data.
- ramData_in, in, 8, RAM read byte, valid one cycle after its address is driven.
- rdE_out, out, 1, registered write enable to MEM/WB.
- rdIdx_out, out, 5, registered destination index.
- rdData_out, out, 32, registered result.
- stallReq_out, out, 1, combinational stall request; while it is high, upstream holds all *_in stable.
- ramAddr_out, out, 32, RAM byte address (combinational).
- ramData_out, out, 8, RAM write byte (combinational).
- ramWE_out, out, 1, RAM write strobe (combinational).

Function
REQ-003 The state machine SHALL have four states: IDLE, LOAD, STORE and DONE. A 2-bit byte counter cnt and a 32-bit load buffer buf SHALL support it.
REQ-004 The access size N SHALL be 1 for LB, LBU and SB; 2 for LH, LHU and SH; and 4 for LW and SW.
REQ-005 IDLE with NONE SHALL give a pass-through with 1-cycle latency:
- rdE_out, rdIdx_out and rdData_out take rdE_in, rdIdx_in and rdData_in at the next edge.
- stallReq_out=0 and ramWE_out=0.
REQ-006 IDLE with a load SHALL:
- drive ramAddr_out=memAddr_in with ramWE_out=0;
- set cnt<=1 and go to LOAD;
- assert stallReq_out=1.
REQ-007 IDLE with a store SHALL:
- drive ramAddr_out=memAddr_in, ramData_out=memData_in[7:0] and ramWE_out=1;
- set cnt<=1;
- go to DONE if N=1, else go to STORE;
- assert stallReq_out=1.
REQ-008 Each LOAD cycle SHALL:
- capture buf byte (cnt-1) <= ramData_in;
- if cnt<N, drive ramAddr_out=memAddr_in+cnt and set cnt<=cnt+1;
- if cnt=N, go to DONE;
- assert stallReq_out=1 and ramWE_out=0.
REQ-009 Each STORE cycle SHALL:
- drive ramAddr_out=memAddr_in+cnt, ramData_out=memData_in byte cnt and ramWE_out=1;
- set cnt<=cnt+1;
- go to DONE after byte N-1;
- assert stallReq_out=1.
REQ-010 DONE SHALL:
- deassert stallReq_out (=0) and ramWE_out (=0);
- at the edge, register rdIdx_out=rdIdx_in;
- for loads, register rdE_out=rdE_in and rdData_out=the extended buf;
- for stores, register rdE_out=0 and rdData_out=0;
- return to IDLE.
REQ-011 Load extension SHALL work as follows:
- LB and LH sign-extend bit 7 or bit 15 respectively.
- LBU and LHU zero-extend.
- LW uses buf unmodified.
- Bytes are little-endian, so byte i lands in bits [8i+7:8i].
REQ-012 On every edge where stallReq_out=1, the block SHALL register a bubble: rdE_out<=0, rdIdx_out<=0, rdData_out<=0.
REQ-013 Address arithmetic SHALL be 32-bit modulo 2^32: 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-014 Unaligned addresses SHALL be legal and need no special handling, because every access is byte-serial.
REQ-015 Total cycles per operation SHALL be:
- a load takes N+2 cycles (IDLE + N×LOAD + DONE);
- a store takes N+1 cycles (IDLE + (N-1)×STORE + DONE);
- stallReq_out is high for all cycles except DONE.
REQ-016 When not driving a RAM access (state DONE, or IDLE with NONE), the block SHALL drive ramAddr_out=0 and ramData_out=0.
REQ-017 After DONE, back-to-back memory ops SHALL start in the very next cycle (IDLE) with no extra idle cycle.

Reset
REQ-018 With rst_in=1 at an edge, the block SHALL set state=IDLE, cnt=0, buf=0, rdE_out=0, rdIdx_out=0 and rdData_out=0.
REQ-019 While rst_in=1, the block SHALL hold ramWE_out=0, stallReq_out=0, ramAddr_out=0 and ramData_out=0 combinationally.
REQ-020 A reset in the middle of an operation SHALL abort it with no further RAM write. The first cycle after reset is IDLE and re-evaluates memOp_in.

Verification
REQ-021 Pass-through: memOp=NONE, rdE=1, rdIdx=5, rdData=0x0000F0F0 -> the next cycle shows rdE_out=1, rdIdx_out=5, rdData_out=0x0000F0F0, stallReq_out=0.
REQ-022 LW: RAM[0x100..0x103]=78,56,34,12, rdIdx=3 ->
- stallReq_out is high for 5 cycles;
- ramAddr_out steps 0x100..0x103;
- after DONE, rdData_out=0x12345678 and rdE_out=1.
REQ-023 LB/LBU: RAM[0x20]=0x80 -> LB gives 0xFFFFFF80 and LBU gives 0x00000080. LH at 0x21 with bytes 0x80,0xFF gives 0xFFFFFF80.
REQ-024 SW: addr 0x200, data 0xDEADBEEF ->
- ramWE_out=1 for 4 cycles, writing 0xEF, 0xBE, 0xAD, 0xDE to 0x200..0x203;
- stallReq_out is high for 4 cycles;
- rdE_out=0 after DONE.
REQ-025 Wrap: LH at 0xFFFFFFFF -> ramAddr_out is 0xFFFFFFFF, then 0x00000000.
REQ-026 Reset mid-SW: rst_in=1 during the second STORE cycle -> the next cycle shows ramWE_out=0 and state IDLE, and no byte is written to 0x202 or 0x203.
